pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage LEGv8 core. Drives PC and pipeline-register

---
 rtl/pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl : pipeline sequencing controller for the 5-stage LEGv8 core.
//
// Generates the PC and pipeline-register write enables and bubble flushes.
// It handles these events:
//   - load-use hazards (one-cycle bubble into ID/EX),
//   - taken branches resolved in MEM (squash IF/ID, ID/EX and EX/MEM),
//   - data-memory wait states (freeze, with a sticky timeout flag),
//   - drain-to-halt on request, and leaving the halt on a resume pulse.
// All outputs are combinational from the current state and inputs.
//
// Optional feature: define PIPE_CTRL_PERF_CNT_EN to build the saturating
// stall_cnt / flush_cnt performance counters. Without the macro, both outputs
// are tied to zero and no counter flops are built.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_rn, id_rm          ID-stage source register addresses
//   id_uses_rn/rm         ID instruction actually reads that source
//   ex_memread, ex_rd     EX-stage load flag and destination register
//   mem_branch_taken      CBZ/CBNZ taken, resolved in MEM
//   mem_access            MEM instruction reads or writes data memory
//   dmem_ready            data memory completes the access this cycle
//   halt_req, resume      halt request (level) / leave HALTED (pulse)
//   pc_en, ifid_en        PC and IF/ID write enables
//   pipe_en               ID/EX, EX/MEM, MEM/WB write enable
//   *_flush               load a bubble into that pipeline register
//   halted                controller is in HALTED
//   mem_err               sticky data-memory wait timeout
//   stall_cnt, flush_cnt  performance counters (optional feature)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int RA_W      = 5,
   parameter int DRAIN_CYC = 4,
   parameter int MAX_WAIT  = 16,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RA_W-1:0]  id_rn,
   input  logic [RA_W-1:0]  id_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic             ex_memread,
   input  logic [RA_W-1:0]  ex_rd,
   input  logic             mem_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             pipe_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } state_t;

   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
   localparam logic [RA_W-1:0]    XZR       = RA_W'(31);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
   localparam logic [DRAIN_W-1:0] DRAIN_LEN = DRAIN_W'(DRAIN_CYC);

   state_t              state_q, state_d;
   state_t              ret_q, ret_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic                halt_pend_q, halt_pend_d;
   logic                mem_err_q, mem_err_set;
   logic                lu;
   logic                eval_active;  // cycle is evaluated with the run/drain rules
   state_t              eval_st;      // which of RUN/DRAIN the cycle is evaluated as
   logic                stall_inc, flush_inc;

   // Loads into XZR never write the register file, so they cannot cause a hazard.
   assign lu = ex_memread && (ex_rd != XZR) &&
               ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

   // NOTE: every signal written here gets a default first, so no path can leave
   // one unassigned and infer a latch.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halted      = 1'b0;
      state_d     = state_q;
      ret_d       = ret_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      halt_pend_d = halt_pend_q;
      eval_active = 1'b0;
      eval_st     = ST_RUN;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;

      case (state_q)
         ST_RUN, ST_DRAIN: begin
            if (mem_access && !dmem_ready) begin
               // Memory not ready: freeze everything, send a bubble to WB.
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               pipe_en     = 1'b0;
               memwb_flush = 1'b1;
               ret_d       = state_q;
               state_d     = ST_MEM_WAIT;
               wait_cnt_d  = WAIT_W'(1);
               stall_inc   = 1'b1;
            end else begin
               eval_active = 1'b1;
               eval_st     = state_q;
            end
         end
         ST_MEM_WAIT: begin
            if (halt_req) halt_pend_d = 1'b1;
            if (!dmem_ready) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               pipe_en     = 1'b0;
               memwb_flush = 1'b1;
               stall_inc   = 1'b1;
               if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
            end else begin
               // Access completes: this cycle behaves as the state we left.
               eval_active = 1'b1;
               eval_st     = ret_q;
               state_d     = ret_q;
            end
         end
         ST_HALTED: begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
            halted  = 1'b1;
            if (resume) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (eval_active) begin
         if (mem_branch_taken) begin
            // Branch wins over a load-use stall: the stalled instruction is squashed.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_en       = 1'b1;
            flush_inc   = 1'b1;
         end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
         end

         if (eval_st == ST_DRAIN) begin
            // Stop fetching, but still let a taken branch load its target into PC.
            if (!mem_branch_taken) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
            if (drain_cnt_q <= DRAIN_W'(1)) begin
               drain_cnt_d = '0;
               state_d     = ST_HALTED;
            end else begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
         end else if ((state_q == ST_RUN) && (halt_req || halt_pend_q)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LEN;
            halt_pend_d = 1'b0;
         end
      end

      mem_err_set = (state_d == ST_MEM_WAIT) && (wait_cnt_d == WAIT_MAX);

      // Reset holds the whole pipe in bubbles regardless of state.
      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         pipe_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
         halted      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         ret_q       <= ST_RUN;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         halt_pend_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         halt_pend_q <= halt_pend_d;
         if (mem_err_set) mem_err_q <= 1'b1;
      end
   end

   assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = stall_inc ^ flush_inc;
   assign stall_cnt   = '0;
   assign flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl.
// Inputs change 1 ns after a rising edge. Combinational outputs are checked
// 3 ns later, well before the next edge.
// Control vector layout:
//   {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush,
//    memwb_flush, halted}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_ctrl;

   localparam int RA_W  = 5;
   localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [7:0] C_RESET  = 8'b000_1111_0;
   localparam logic [7:0] C_RUN    = 8'b111_0000_0;
   localparam logic [7:0] C_LU     = 8'b001_0100_0;
   localparam logic [7:0] C_BRANCH = 8'b111_1110_0;
   localparam logic [7:0] C_WAIT   = 8'b000_0001_0;
   localparam logic [7:0] C_DRAIN  = 8'b011_1000_0;
   localparam logic [7:0] C_HALTED = 8'b000_0000_1;

   logic            clk = 1'b0;
   logic            reset;
   logic [RA_W-1:0] id_rn, id_rm, ex_rd;
   logic            id_uses_rn, id_uses_rm, ex_memread;
   logic            mem_branch_taken, mem_access, dmem_ready, halt_req, resume;
   logic            pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic            halted, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [7:0]      ctrl;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   pipe_ctrl #(.RA_W(RA_W), .DRAIN_CYC(4), .MAX_WAIT(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
      .halt_req(halt_req), .resume(resume),
      .pc_en(pc_en), .ifid_en(ifid_en), .pipe_en(pipe_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halted(halted), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   assign ctrl = {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, exmem_flush,
                  memwb_flush, halted};

   // Advance one cycle, then wait until outputs for the new inputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rn = '0; id_rm = '0; ex_rd = '0;
      id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_memread = 1'b0;
      mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
      halt_req = 1'b0; resume = 1'b0;
   endtask

   task automatic check_ctrl(input string name, input logic [7:0] exp);
      #3;
      n_checks++;
      if (ctrl !== exp) $display("FAIL %s: ctrl=%b expected %b", name, ctrl, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #2;
      n_checks++;
      if (ctrl !== C_RESET) $display("FAIL reset_ctrl: ctrl=%b expected %b", ctrl, C_RESET);
      else n_pass++;
      n_checks++;
      if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b expected 0", mem_err);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      step();
      check_ctrl("run_after_reset", C_RUN);
   endtask

   task automatic test_load_use();
      step();
      ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3; id_uses_rn = 1'b1;
      check_ctrl("lu_rn_stall", C_LU);
      exp_stall++;
      step();
      ex_memread = 1'b0;
      check_ctrl("lu_rn_released", C_RUN);
      step();
      ex_memread = 1'b1; ex_rd = 5'd7; id_rn = 5'd0; id_rm = 5'd7; id_uses_rn = 1'b0;
      id_uses_rm = 1'b1;
      check_ctrl("lu_rm_stall", C_LU);
      exp_stall++;
      step();
      id_uses_rm = 1'b0;
      check_ctrl("lu_unused_src", C_RUN);
      step();
      ex_rd = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1;
      check_ctrl("lu_xzr_no_stall", C_RUN);
      step();
      idle_inputs();
   endtask

   task automatic test_branch();
      step();
      ex_memread = 1'b1; ex_rd = 5'd4; id_rn = 5'd4; id_uses_rn = 1'b1;
      mem_branch_taken = 1'b1;
      check_ctrl("branch_over_lu", C_BRANCH);
      exp_flush++;
      step();
      idle_inputs();
      check_ctrl("after_branch", C_RUN);
      n_checks++;
      if (flush_cnt !== (PERF ? CNT_W'(exp_flush) : '0))
         $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, PERF ? exp_flush : 0);
      else n_pass++;
   endtask

   task automatic test_mem_wait();
      step();
      mem_access = 1'b1; dmem_ready = 1'b0;
      check_ctrl("wait_c1", C_WAIT);
      step();
      check_ctrl("wait_c2", C_WAIT);
      step();
      check_ctrl("wait_c3", C_WAIT);
      exp_stall += 3;
      step();
      dmem_ready = 1'b1;
      check_ctrl("wait_done_advance", C_RUN);
      step();
      mem_access = 1'b0;
      check_ctrl("wait_back_in_run", C_RUN);
      n_checks++;
      if (stall_cnt !== (PERF ? CNT_W'(exp_stall) : '0))
         $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, PERF ? exp_stall : 0);
      else n_pass++;
   endtask

   task automatic test_drain_halt(input string tag);
      for (int i = 0; i < 4; i++) begin
         step();
         halt_req = 1'b0;
         check_ctrl({tag, "_drain"}, C_DRAIN);
      end
      step();
      check_ctrl({tag, "_halted"}, C_HALTED);
      step();
      halt_req = 1'b1;
      check_ctrl({tag, "_halt_req_ignored"}, C_HALTED);
      step();
      halt_req = 1'b0; resume = 1'b1;
      check_ctrl({tag, "_resume_cycle"}, C_HALTED);
      step();
      resume = 1'b0;
      check_ctrl({tag, "_resumed_run"}, C_RUN);
   endtask

   task automatic test_halt();
      step();
      halt_req = 1'b1;
      check_ctrl("halt_req_run_cycle", C_RUN);
      test_drain_halt("halt");
   endtask

   task automatic test_halt_pending();
      step();
      mem_access = 1'b1; dmem_ready = 1'b0;
      check_ctrl("pend_wait_enter", C_WAIT);
      step();
      halt_req = 1'b1;
      check_ctrl("pend_wait_halt_req", C_WAIT);
      exp_stall += 2;
      step();
      halt_req = 1'b0; dmem_ready = 1'b1; mem_access = 1'b0;
      check_ctrl("pend_wait_done", C_RUN);
      step();
      check_ctrl("pend_run_to_drain", C_RUN);
      test_drain_halt("pend");
   endtask

   task automatic test_mem_err();
      step();
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         #3;
         n_checks++;
         if (ctrl !== C_WAIT) $display("FAIL timeout_wait_%0d: ctrl=%b expected %b", i, ctrl, C_WAIT);
         else n_pass++;
         step();
         n_checks++;
         if (mem_err !== (i >= 16))
            $display("FAIL mem_err_after_%0d: got %b expected %b", i, mem_err, i >= 16);
         else n_pass++;
      end
      exp_stall += 20;
      dmem_ready = 1'b1;
      check_ctrl("timeout_release", C_RUN);
      step();
      mem_access = 1'b0;
      n_checks++;
      if (mem_err !== 1'b1) $display("FAIL mem_err_sticky: got %b expected 1", mem_err);
      else n_pass++;
      n_checks++;
      if (stall_cnt !== (PERF ? CNT_W'(exp_stall) : '0))
         $display("FAIL stall_cnt_total: got %0d expected %0d", stall_cnt, PERF ? exp_stall : 0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_drain();
      step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      check_ctrl("pre_reset_drain", C_DRAIN);
      #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (ctrl !== C_RESET) $display("FAIL async_reset_ctrl: ctrl=%b expected %b", ctrl, C_RESET);
      else n_pass++;
      n_checks++;
      if (mem_err !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0)
         $display("FAIL async_reset_state: mem_err=%b stall=%0d flush=%0d expected 0/0/0",
                  mem_err, stall_cnt, flush_cnt);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check_ctrl("no_drain_after_reset", C_RUN);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_halt();
      test_halt_pending();
      test_mem_err();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
